// File: rtl/direction_cmd.sv
// Direction command stage: synchronises and debounces four active-low buttons,
// commits a single pressed button to a 2-bit code, and generates the display tick.
module direction_cmd #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int TICK_DIV        = 5_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn_n,
    output logic [1:0] direc,
    output logic       timer,
    output logic       dir_valid,
    output logic       dir_changed
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TCNT_LAST = TW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HOLD} state_t;

    // Handshake-free block: btn_n is an asynchronous level input and every output
    // is a registered level, except dir_changed which is a one-cycle pulse.
    logic [3:0]    sync1, sync2;
    logic [3:0]    btn;
    logic          cand_ok;
    logic [1:0]    cand;
    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [1:0]    cand_reg, cand_reg_next;
    logic          commit;
    logic [TW-1:0] tcnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 4'hF;
            sync2 <= 4'hF;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
        end
    end

    assign btn = ~sync2;

    // Only a single pressed button forms a valid candidate.
    always_comb begin
        cand_ok = 1'b1;
        cand    = 2'd0;
        case (btn)
            4'b0001: cand = 2'd0;
            4'b0010: cand = 2'd1;
            4'b0100: cand = 2'd2;
            4'b1000: cand = 2'd3;
            default: cand_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            cand_reg <= 2'd0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            cand_reg <= cand_reg_next;
        end
    end

    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        cand_reg_next = cand_reg;
        commit        = 1'b0;
        case (state)
            IDLE: begin
                if (cand_ok) begin
                    cand_reg_next = cand;
                    cnt_next      = '0;
                    state_next    = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (cand_ok && cand == cand_reg) begin
                    if (cnt == CNT_LAST) begin
                        commit     = 1'b1;
                        state_next = HOLD;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end else begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end
            end
            HOLD: begin
                // A held button never re-commits; it must be released first.
                if (!(cand_ok && cand == cand_reg)) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            direc       <= 2'd0;
            dir_valid   <= 1'b0;
            dir_changed <= 1'b0;
        end else begin
            dir_changed <= 1'b0;
            if (commit) begin
                direc       <= cand_reg;
                dir_valid   <= 1'b1;
                dir_changed <= !dir_valid || (cand_reg != direc);
            end
        end
    end

    // Free-running display tick, independent of the button path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt  <= '0;
            timer <= 1'b0;
        end else if (tcnt == TCNT_LAST) begin
            tcnt  <= '0;
            timer <= ~timer;
        end else begin
            tcnt <= tcnt + 1'b1;
        end
    end

endmodule
